// File: rtl/ifetch_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg : shared widths, PC step, fetch FSM encoding and alignment helper
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ifetch_pkg;
   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;
   localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } fetch_state_e;

   function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction
endpackage

`default_nettype wire

// File: rtl/ifetch_pc.sv
// ---------------------------------------------------------------------------
// ifetch_pc : fetch PC register with increment, aligned redirect and fault
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ifetch_pc
   import ifetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc_i,
   input  logic              redir_valid_i,
   input  logic [ADDR_W-1:0] redir_pc_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              fault_o,
   output logic              redir_ok_o
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              fault_q, fault_d;
   logic              w_redir_ok;

   assign w_redir_ok = redir_valid_i && is_aligned(redir_pc_i);

   // An aligned redirect always beats the increment; a misaligned one only flags.
   always_comb begin
      pc_d    = pc_q;
      fault_d = fault_q;
      if (w_redir_ok) begin
         pc_d    = redir_pc_i;
         fault_d = 1'b0;
      end else begin
         if (redir_valid_i) fault_d = 1'b1;
         if (inc_i)         pc_d    = pc_q + PC_STEP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         fault_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         fault_q <= fault_d;
      end
   end

   assign pc_o       = pc_q;
   assign fault_o    = fault_q;
   assign redir_ok_o = w_redir_ok;

endmodule

`default_nettype wire

// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch : request/response instruction fetch feeding the IR register
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ifetch
   import ifetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               fetch_req,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic               mem_rvalid,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic               ir_en,
   output logic [INSTR_W-1:0] ir_instr,
   output logic [ADDR_W-1:0]  pc_out,
   output logic               busy,
   output logic               fault
);

   fetch_state_e       state_q;
   logic               kill_q;
   logic               mem_req_q;
   logic [ADDR_W-1:0]  addr_q;
   logic               ir_en_q;
   logic [INSTR_W-1:0] ir_instr_q;
   logic [ADDR_W-1:0]  pc_out_q;
   logic               busy_q;

   logic [ADDR_W-1:0]  w_fetch_pc;
   logic               w_redir_ok;
   logic               w_deliver;

   // A response is delivered only if neither a stored nor a same-cycle redirect killed it.
   assign w_deliver = (state_q == ST_WAIT) && mem_rvalid && !kill_q && !w_redir_ok;

   ifetch_pc #(
      .RESET_PC      (RESET_PC)
   ) u_pc (
      .clk           (clk),
      .rst_n         (rst_n),
      .inc_i         (w_deliver),
      .redir_valid_i (redirect_valid),
      .redir_pc_i    (redirect_pc),
      .pc_o          (w_fetch_pc),
      .fault_o       (fault),
      .redir_ok_o    (w_redir_ok)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         kill_q     <= 1'b0;
         mem_req_q  <= 1'b0;
         addr_q     <= RESET_PC;
         ir_en_q    <= 1'b0;
         ir_instr_q <= '0;
         pc_out_q   <= RESET_PC;
         busy_q     <= 1'b0;
      end else begin
         ir_en_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (fetch_req) begin
                  state_q   <= ST_REQ;
                  mem_req_q <= 1'b1;
                  busy_q    <= 1'b1;
                  addr_q    <= w_redir_ok ? redirect_pc : w_fetch_pc;
               end
            end
            ST_REQ: begin
               if (w_redir_ok) kill_q <= 1'b1;
               if (mem_ack) begin
                  state_q   <= ST_WAIT;
                  mem_req_q <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  kill_q  <= 1'b0;
                  if (w_deliver) begin
                     ir_en_q    <= 1'b1;
                     ir_instr_q <= mem_rdata;
                     pc_out_q   <= addr_q;
                  end
               end else if (w_redir_ok) begin
                  kill_q <= 1'b1;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               mem_req_q <= 1'b0;
               busy_q    <= 1'b0;
               kill_q    <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_addr = addr_q;
   assign ir_en    = ir_en_q;
   assign ir_instr = ir_instr_q;
   assign pc_out   = pc_out_q;
   assign busy     = busy_q;

endmodule

`default_nettype wire
